// File: rtl/store_queue_if.sv
// -----------------------------------------------------------------------------
// store_queue_if
// Bundles every handshake and data signal of the store queue: dispatch alloc,
// AGU fill, ROB commit/flush, the data-cache write port, and the load
// forwarding query.
//   master : the environment (dispatch, AGU, ROB, cache, load pipe)
//   slave  : the store queue itself
// -----------------------------------------------------------------------------
interface store_queue_if #(
    parameter int SQ_SIZE = 8,
    parameter int XLEN    = 32
);
    localparam int IDX_W = $clog2(SQ_SIZE);

    // dispatch
    logic             alloc_valid;
    logic             alloc_ready;
    logic [IDX_W-1:0] alloc_idx;
    // AGU
    logic             fill_valid;
    logic [IDX_W-1:0] fill_idx;
    logic [XLEN-1:0]  fill_addr;
    logic [XLEN-1:0]  fill_data;
    logic [1:0]       fill_width;
    // ROB
    logic             commit_valid;
    logic             flush_valid;
    // data-cache write port
    logic             mem_req_valid;
    logic             mem_req_ready;
    logic [XLEN-1:0]  mem_req_addr;
    logic [XLEN-1:0]  mem_req_data;
    logic [3:0]       mem_req_mask;
    // load forwarding query
    logic             ld_valid;
    logic [XLEN-1:0]  ld_addr;
    logic [1:0]       ld_width;
    logic [IDX_W-1:0] ld_sq_tail;
    logic             fwd_hit;
    logic [XLEN-1:0]  fwd_data;
    logic             fwd_stall;
    // status
    logic [IDX_W:0]   count;

    modport master (
        output alloc_valid, fill_valid, fill_idx, fill_addr, fill_data, fill_width,
               commit_valid, flush_valid, mem_req_ready,
               ld_valid, ld_addr, ld_width, ld_sq_tail,
        input  alloc_ready, alloc_idx, mem_req_valid, mem_req_addr, mem_req_data,
               mem_req_mask, fwd_hit, fwd_data, fwd_stall, count
    );

    modport slave (
        input  alloc_valid, fill_valid, fill_idx, fill_addr, fill_data, fill_width,
               commit_valid, flush_valid, mem_req_ready,
               ld_valid, ld_addr, ld_width, ld_sq_tail,
        output alloc_ready, alloc_idx, mem_req_valid, mem_req_addr, mem_req_data,
               mem_req_mask, fwd_hit, fwd_data, fwd_stall, count
    );
endinterface

// File: rtl/store_queue.sv
// -----------------------------------------------------------------------------
// store_queue
// Circular store queue for the out-of-order LSU. Stores are allocated at tail
// by dispatch, filled by the AGU, committed in order by the ROB and drained
// from head to the data cache. Loads query it combinationally for
// store-to-load forwarding against the stores older than themselves.
//   clk     : clock
//   reset_n : asynchronous active-low reset
//   sq      : store_queue_if.slave (alloc / fill / commit / flush / mem_req /
//             forwarding query / count)
// -----------------------------------------------------------------------------
module store_queue #(
    parameter int SQ_SIZE = 8,
    parameter int XLEN    = 32,
    parameter int IDX_W   = $clog2(SQ_SIZE)
) (
    input  logic          clk,
    input  logic          reset_n,
    store_queue_if.slave  sq
);
    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [IDX_W:0]   cnt_t;

    localparam cnt_t CNT_FULL = cnt_t'(SQ_SIZE);

    // per-entry control flags
    logic [SQ_SIZE-1:0] valid_q, valid_d;
    logic [SQ_SIZE-1:0] addr_valid_q, addr_valid_d;
    logic [SQ_SIZE-1:0] data_valid_q, data_valid_d;
    logic [SQ_SIZE-1:0] committed_q, committed_d;
    // per-entry payload
    logic [XLEN-3:0]    waddr_q [SQ_SIZE];
    logic [3:0]         mask_q  [SQ_SIZE];
    logic [XLEN-1:0]    data_q  [SQ_SIZE];

    idx_t head_q, head_d, tail_q, tail_d, cmt_q, cmt_d;
    cnt_t count_q, count_d, flushed_n;

    logic alloc_fire, fill_fire, commit_fire, drain_fire;

    function automatic logic [3:0] byte_mask(input logic [1:0] width, input logic [1:0] ofs);
        case (width)
            2'd0:    return 4'b0001 << ofs;
            2'd1:    return 4'b0011 << ofs;
            default: return 4'b1111;
        endcase
    endfunction

    assign sq.alloc_ready = (count_q != CNT_FULL);
    assign sq.alloc_idx   = tail_q;
    assign sq.count       = count_q;

    // A flush squashes a same-cycle alloc, so it never takes an entry.
    assign alloc_fire  = sq.alloc_valid && sq.alloc_ready && !sq.flush_valid;
    assign fill_fire   = sq.fill_valid && valid_q[sq.fill_idx];
    // Commit only targets a live, not-yet-committed entry; anything else is a
    // protocol error from the ROB and is dropped.
    assign commit_fire = sq.commit_valid && valid_q[cmt_q] && !committed_q[cmt_q];
    assign drain_fire  = sq.mem_req_valid && sq.mem_req_ready;

    // ---------------- next-state ----------------
    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can infer a latch.
        valid_d      = valid_q;
        addr_valid_d = addr_valid_q;
        data_valid_d = data_valid_q;
        committed_d  = committed_q;
        flushed_n    = '0;

        if (fill_fire) begin
            addr_valid_d[sq.fill_idx] = 1'b1;
            data_valid_d[sq.fill_idx] = 1'b1;
        end
        if (alloc_fire) begin
            valid_d[tail_q]      = 1'b1;
            addr_valid_d[tail_q] = 1'b0;
            data_valid_d[tail_q] = 1'b0;
            committed_d[tail_q]  = 1'b0;
        end
        if (commit_fire) begin
            committed_d[cmt_q] = 1'b1;
        end
        if (drain_fire) begin
            valid_d[head_q]      = 1'b0;
            addr_valid_d[head_q] = 1'b0;
            data_valid_d[head_q] = 1'b0;
            committed_d[head_q]  = 1'b0;
        end
        // Flush sees the post-commit view, so a same-cycle commit survives it.
        if (sq.flush_valid) begin
            for (int i = 0; i < SQ_SIZE; i++) begin
                if (valid_d[i] && !committed_d[i]) begin
                    valid_d[i]      = 1'b0;
                    addr_valid_d[i] = 1'b0;
                    data_valid_d[i] = 1'b0;
                    flushed_n       = flushed_n + cnt_t'(1);
                end
            end
        end

        head_d  = head_q + idx_t'(drain_fire);
        cmt_d   = cmt_q + idx_t'(commit_fire);
        tail_d  = sq.flush_valid ? cmt_d : tail_q + idx_t'(alloc_fire);
        count_d = count_q + cnt_t'(alloc_fire) - cnt_t'(drain_fire) - flushed_n;
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q      <= '0;
            addr_valid_q <= '0;
            data_valid_q <= '0;
            committed_q  <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            cmt_q        <= '0;
            count_q      <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            valid_q      <= valid_d;
            addr_valid_q <= addr_valid_d;
            data_valid_q <= data_valid_d;
            committed_q  <= committed_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            cmt_q        <= cmt_d;
            count_q      <= count_d;
        end
    end

    // NOTE: payload storage has no reset; the flags qualify every read and the outputs are gated.
    always_ff @(posedge clk) begin
        if (fill_fire) begin
            waddr_q[sq.fill_idx] <= sq.fill_addr[XLEN-1:2];
            mask_q[sq.fill_idx]  <= byte_mask(sq.fill_width, sq.fill_addr[1:0]);
            data_q[sq.fill_idx]  <= sq.fill_data << {sq.fill_addr[1:0], 3'b000};
        end
    end

    // ---------------- drain port ----------------
    assign sq.mem_req_valid = valid_q[head_q] && committed_q[head_q]
                           && addr_valid_q[head_q] && data_valid_q[head_q];
    assign sq.mem_req_addr  = sq.mem_req_valid ? {waddr_q[head_q], 2'b00} : '0;
    assign sq.mem_req_data  = sq.mem_req_valid ? data_q[head_q] : '0;
    assign sq.mem_req_mask  = sq.mem_req_valid ? mask_q[head_q] : '0;

    // ---------------- store-to-load forwarding ----------------
    logic [3:0]      ld_mask;
    idx_t            n_older, scan_idx, sel_idx;
    logic            decided, hit, stall;
    logic [XLEN-1:0] keep_mask, shifted;

    always_comb begin
        ld_mask  = byte_mask(sq.ld_width, sq.ld_addr[1:0]);
        // Distance from head gives program order independent of wrap-around.
        n_older  = sq.ld_sq_tail - head_q;
        decided  = 1'b0;
        hit      = 1'b0;
        stall    = 1'b0;
        sel_idx  = '0;
        scan_idx = '0;
        // k=0 is the youngest older store, k=n_older-1 the oldest.
        for (int k = 0; k < SQ_SIZE; k++) begin
            scan_idx = sq.ld_sq_tail - idx_t'(k + 1);
            if (!decided && sq.ld_valid && (idx_t'(k) < n_older) && valid_q[scan_idx]) begin
                if (!addr_valid_q[scan_idx]) begin
                    decided = 1'b1;
                    stall   = 1'b1;
                end else if (waddr_q[scan_idx] == sq.ld_addr[XLEN-1:2]
                             && (mask_q[scan_idx] & ld_mask) != 4'b0000) begin
                    decided = 1'b1;
                    // Only a store covering every load byte can supply it alone.
                    if ((ld_mask & ~mask_q[scan_idx]) == 4'b0000 && data_valid_q[scan_idx]) begin
                        hit     = 1'b1;
                        sel_idx = scan_idx;
                    end else begin
                        stall = 1'b1;
                    end
                end
            end
        end

        case (sq.ld_width)
            2'd0:    keep_mask = XLEN'(32'h0000_00FF);
            2'd1:    keep_mask = XLEN'(32'h0000_FFFF);
            default: keep_mask = '1;
        endcase
        shifted = data_q[sel_idx] >> {sq.ld_addr[1:0], 3'b000};
    end

    assign sq.fwd_hit   = hit;
    assign sq.fwd_stall = stall;
    assign sq.fwd_data  = hit ? (shifted & keep_mask) : '0;

endmodule

// File: tb/tb_store_queue.sv
// -----------------------------------------------------------------------------
// tb_store_queue
// Directed bench for store_queue: hand-computed forwarding vectors applied
// from a table, plus sequences for fill-up, drain, wrap-around and flush.
// -----------------------------------------------------------------------------
module tb_store_queue;
    localparam int SQ_SIZE = 8;
    localparam int XLEN    = 32;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    store_queue_if #(.SQ_SIZE(SQ_SIZE), .XLEN(XLEN)) sq ();

    store_queue #(.SQ_SIZE(SQ_SIZE), .XLEN(XLEN)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sq      (sq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ld_valid;
        logic [31:0] addr;
        logic [1:0]  width;
        logic [2:0]  tail;
        logic        exp_hit;
        logic        exp_stall;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        sq.alloc_valid   = 1'b0;
        sq.fill_valid    = 1'b0;
        sq.fill_idx      = '0;
        sq.fill_addr     = '0;
        sq.fill_data     = '0;
        sq.fill_width    = '0;
        sq.commit_valid  = 1'b0;
        sq.flush_valid   = 1'b0;
        sq.mem_req_ready = 1'b0;
        sq.ld_valid      = 1'b0;
        sq.ld_addr       = '0;
        sq.ld_width      = '0;
        sq.ld_sq_tail    = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        cyc();
        cyc();
        reset_n = 1'b1;
        #1;
    endtask

    task automatic do_alloc();
        sq.alloc_valid = 1'b1;
        cyc();
        sq.alloc_valid = 1'b0;
    endtask

    task automatic do_fill(input logic [2:0] idx, input logic [31:0] addr,
                           input logic [31:0] data, input logic [1:0] width);
        sq.fill_valid = 1'b1;
        sq.fill_idx   = idx;
        sq.fill_addr  = addr;
        sq.fill_data  = data;
        sq.fill_width = width;
        cyc();
        sq.fill_valid = 1'b0;
    endtask

    task automatic do_commit();
        sq.commit_valid = 1'b1;
        cyc();
        sq.commit_valid = 1'b0;
    endtask

    task automatic run_vecs(input string tag);
        foreach (vecs[i]) begin
            sq.ld_valid   = vecs[i].ld_valid;
            sq.ld_addr    = vecs[i].addr;
            sq.ld_width   = vecs[i].width;
            sq.ld_sq_tail = vecs[i].tail;
            #1;
            check($sformatf("%s[%0d] fwd_hit", tag, i),   64'(sq.fwd_hit),   64'(vecs[i].exp_hit));
            check($sformatf("%s[%0d] fwd_stall", tag, i), 64'(sq.fwd_stall), 64'(vecs[i].exp_stall));
            check($sformatf("%s[%0d] fwd_data", tag, i),  64'(sq.fwd_data),  64'(vecs[i].exp_data));
        end
        sq.ld_valid = 1'b0;
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // ---------------- reset state and fill-up ----------------
        do_reset();
        check("rst alloc_ready", 64'(sq.alloc_ready), 64'd1);
        check("rst alloc_idx", 64'(sq.alloc_idx), 64'd0);
        check("rst count", 64'(sq.count), 64'd0);
        check("rst mem_req_valid", 64'(sq.mem_req_valid), 64'd0);
        check("rst mem_req_addr", 64'(sq.mem_req_addr), 64'd0);
        check("rst mem_req_data", 64'(sq.mem_req_data), 64'd0);
        check("rst mem_req_mask", 64'(sq.mem_req_mask), 64'd0);
        check("rst fwd_hit", 64'(sq.fwd_hit), 64'd0);
        check("rst fwd_stall", 64'(sq.fwd_stall), 64'd0);

        for (int i = 0; i < SQ_SIZE; i++) begin
            check($sformatf("fill alloc_idx %0d", i), 64'(sq.alloc_idx), 64'(i));
            do_alloc();
        end
        check("full alloc_ready", 64'(sq.alloc_ready), 64'd0);
        check("full count", 64'(sq.count), 64'd8);
        do_alloc();
        check("9th alloc count", 64'(sq.count), 64'd8);
        check("9th alloc tail", 64'(sq.alloc_idx), 64'd0);

        // ---------------- single word store drain ----------------
        do_reset();
        do_alloc();
        do_fill(3'd0, 32'h0000_0100, 32'hAABB_CCDD, 2'd2);
        sq.commit_valid  = 1'b1;
        sq.mem_req_ready = 1'b1;
        #1;
        check("pre-commit mem_req_valid", 64'(sq.mem_req_valid), 64'd0);
        cyc();
        sq.commit_valid = 1'b0;
        check("drain valid", 64'(sq.mem_req_valid), 64'd1);
        check("drain addr", 64'(sq.mem_req_addr), 64'h100);
        check("drain mask", 64'(sq.mem_req_mask), 64'hF);
        check("drain data", 64'(sq.mem_req_data), 64'hAABB_CCDD);
        cyc();
        sq.mem_req_ready = 1'b0;
        check("after drain count", 64'(sq.count), 64'd0);
        check("after drain valid", 64'(sq.mem_req_valid), 64'd0);

        // byte store in the top lane: word address aligned, data lane-shifted
        check("byte alloc_idx", 64'(sq.alloc_idx), 64'd1);
        do_alloc();
        do_fill(3'd1, 32'h0000_0103, 32'h0000_005A, 2'd0);
        do_commit();
        check("byte drain addr", 64'(sq.mem_req_addr), 64'h100);
        check("byte drain mask", 64'(sq.mem_req_mask), 64'h8);
        check("byte drain data", 64'(sq.mem_req_data), 64'h5A00_0000);
        sq.mem_req_ready = 1'b1;
        cyc();
        sq.mem_req_ready = 1'b0;
        check("byte after drain count", 64'(sq.count), 64'd0);

        // ---------------- forwarding table ----------------
        do_reset();
        do_alloc();
        do_alloc();
        do_alloc();
        do_fill(3'd0, 32'h0000_0200, 32'h1122_3344, 2'd2);
        do_fill(3'd1, 32'h0000_0201, 32'h0000_0055, 2'd0);
        // entry 2 stays unfilled (address unknown)
        vecs.delete();
        vecs.push_back('{1'b1, 32'h201, 2'd0, 3'd2, 1'b1, 1'b0, 32'h55});        // youngest wins
        vecs.push_back('{1'b1, 32'h201, 2'd0, 3'd1, 1'b1, 1'b0, 32'h33});        // only idx0 older
        vecs.push_back('{1'b1, 32'h202, 2'd1, 3'd2, 1'b1, 1'b0, 32'h1122});      // idx1 disjoint
        vecs.push_back('{1'b1, 32'h200, 2'd2, 3'd2, 1'b0, 1'b1, 32'h0});         // partial cover
        vecs.push_back('{1'b1, 32'h201, 2'd0, 3'd3, 1'b0, 1'b1, 32'h0});         // idx2 addr unknown
        vecs.push_back('{1'b1, 32'h300, 2'd0, 3'd2, 1'b0, 1'b0, 32'h0});         // other word
        vecs.push_back('{1'b1, 32'h201, 2'd0, 3'd0, 1'b0, 1'b0, 32'h0});         // no older stores
        vecs.push_back('{1'b1, 32'h200, 2'd2, 3'd1, 1'b1, 1'b0, 32'h1122_3344}); // full word
        vecs.push_back('{1'b0, 32'h201, 2'd0, 3'd2, 1'b0, 1'b0, 32'h0});         // query idle
        run_vecs("fwd");

        // ---------------- wrap-around ----------------
        do_reset();
        for (int i = 0; i < 6; i++) do_alloc();
        for (int i = 0; i < 6; i++) do_fill(3'(i), 32'h0000_0800, 32'(i), 2'd2);
        for (int i = 0; i < 6; i++) do_commit();
        sq.mem_req_ready = 1'b1;
        for (int i = 0; i < 20 && sq.count != 0; i++) cyc();
        sq.mem_req_ready = 1'b0;
        check("wrap drained count", 64'(sq.count), 64'd0);
        check("wrap tail", 64'(sq.alloc_idx), 64'd6);
        for (int i = 0; i < 4; i++) do_alloc();
        check("wrap tail after alloc", 64'(sq.alloc_idx), 64'd2);
        check("wrap count", 64'(sq.count), 64'd4);
        do_fill(3'd6, 32'h0000_0500, 32'h0000_0066, 2'd2);
        do_fill(3'd7, 32'h0000_0600, 32'h7777_7777, 2'd2);
        do_fill(3'd0, 32'h0000_0600, 32'h8888_8888, 2'd2);
        do_fill(3'd1, 32'h0000_0600, 32'h9999_9999, 2'd2);
        vecs.delete();
        vecs.push_back('{1'b1, 32'h600, 2'd2, 3'd1, 1'b1, 1'b0, 32'h8888_8888}); // idx0 younger than idx7
        vecs.push_back('{1'b1, 32'h600, 2'd2, 3'd0, 1'b1, 1'b0, 32'h7777_7777});
        vecs.push_back('{1'b1, 32'h600, 2'd2, 3'd2, 1'b1, 1'b0, 32'h9999_9999});
        vecs.push_back('{1'b1, 32'h600, 2'd2, 3'd6, 1'b0, 1'b0, 32'h0});         // tail==head
        vecs.push_back('{1'b1, 32'h502, 2'd1, 3'd7, 1'b1, 1'b0, 32'h0});         // upper half of 0x66
        run_vecs("wrap");

        // ---------------- flush with same-cycle commit and alloc ----------------
        do_reset();
        do_alloc();
        do_alloc();
        do_alloc();
        do_commit();
        sq.commit_valid = 1'b1;
        sq.flush_valid  = 1'b1;
        sq.alloc_valid  = 1'b1;
        cyc();
        idle();
        check("flush count", 64'(sq.count), 64'd2);
        check("flush tail", 64'(sq.alloc_idx), 64'd2);
        check("flush alloc_ready", 64'(sq.alloc_ready), 64'd1);
        do_fill(3'd0, 32'h0000_0700, 32'h0000_CAFE, 2'd2);
        check("flush head drains", 64'(sq.mem_req_valid), 64'd1);
        check("flush head addr", 64'(sq.mem_req_addr), 64'h700);
        do_alloc();
        check("post-flush alloc count", 64'(sq.count), 64'd3);
        check("post-flush alloc tail", 64'(sq.alloc_idx), 64'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard bound so the run always ends even if a sequence stalls.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
